// File: rtl/decode_pkg.sv
// Shared decode-stage types: opcodes, ALU/result-select encodings and the
// control bundle carried from decode into the ID/EX register.
package decode_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_type_e;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        alu_ctrl_e   alu_ctrl;
        logic        alu_src;
    } ctrl_t;

endpackage

// File: rtl/decode_cycle_register_file.sv
// Architectural register file: two combinational reads, one write, x0 tied
// to zero, and a same-cycle write forwarded straight to the read ports.
module register_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);

    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic                       wr_en;

    assign wr_en = we && (wa != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[wa] = wd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) regs_q <= '0;
        else      regs_q <= regs_d;
    end

    // Write-first: a reader in the writing cycle sees the new value.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != 5'd0) rd1 = (wr_en && wa == ra1) ? wd : regs_q[ra1];
        if (ra2 != 5'd0) rd2 = (wr_en && wa == ra2) ? wd : regs_q[ra2];
    end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: main/ALU decode, register read, immediate extension,
// all captured into the ID/EX register; FlushE squashes the control bundle.
module decode_cycle #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            FlushE,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic [2:0]      ALUControlE,
    output logic            ALUSrcE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      RdE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E
);

    import decode_pkg::*;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    imm_type_e       imm_type;
    alu_ctrl_e       alu_dec;

    ctrl_t           ctrl_d, ctrl_q;
    logic [XLEN-1:0] rd1_d, rd1_q, rd2_d, rd2_q;
    logic [XLEN-1:0] imm_d, imm_q;
    logic [XLEN-1:0] pc_d, pc_q, pc4_d, pc4_q;
    logic [4:0]      rd_d, rd_q, rs1_d, rs1_q, rs2_d, rs2_q;

    assign opcode   = InstrD[6:0];
    assign funct3   = InstrD[14:12];
    assign funct7b5 = InstrD[30];
    assign rd_d     = InstrD[11:7];
    assign rs1_d    = InstrD[19:15];
    assign rs2_d    = InstrD[24:20];
    assign pc_d     = PCD;
    assign pc4_d    = PCPlus4D;

    register_file #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1_d),
        .ra2 (rs2_d),
        .rd1 (rd1_d),
        .rd2 (rd2_d),
        .we  (RegWriteW),
        .wa  (RdW),
        .wd  (ResultW)
    );

    // funct7[5] only selects sub for register-register ops; addi ignores it.
    always_comb begin
        alu_dec = ALU_ADD;
        case (funct3)
            3'b000:  alu_dec = (opcode == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    end

    always_comb begin
        ctrl_d   = '0;
        imm_type = IMM_I;
        case (opcode)
            OP_LOAD: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.result_src = RES_MEM;
            end
            OP_STORE: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                imm_type         = IMM_S;
            end
            OP_RTYPE: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_ctrl  = alu_dec;
            end
            OP_IALU: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_ctrl  = alu_dec;
            end
            OP_BRANCH: begin
                ctrl_d.branch   = 1'b1;
                ctrl_d.alu_ctrl = ALU_SUB;
                imm_type        = IMM_B;
            end
            OP_JAL: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.jump       = 1'b1;
                ctrl_d.result_src = RES_PC4;
                imm_type          = IMM_J;
            end
            default: ctrl_d = '0;
        endcase
        if (FlushE) ctrl_d = '0;
    end

    always_comb begin
        imm_d = '0;
        case (imm_type)
            IMM_I: imm_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            IMM_S: imm_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B: imm_d = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                            InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J: imm_d = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12],
                            InstrD[20], InstrD[30:21], 1'b0};
            default: imm_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            pc_q   <= '0;
            pc4_q  <= '0;
            rd_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            imm_q  <= imm_d;
            pc_q   <= pc_d;
            pc4_q  <= pc4_d;
            rd_q   <= rd_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
        end
    end

    assign RegWriteE   = ctrl_q.reg_write;
    assign ResultSrcE  = ctrl_q.result_src;
    assign MemWriteE   = ctrl_q.mem_write;
    assign JumpE       = ctrl_q.jump;
    assign BranchE     = ctrl_q.branch;
    assign ALUControlE = ctrl_q.alu_ctrl;
    assign ALUSrcE     = ctrl_q.alu_src;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign ImmExtE     = imm_q;
    assign PCE         = pc_q;
    assign PCPlus4E    = pc4_q;
    assign RdE         = rd_q;
    assign Rs1E        = rs1_q;
    assign Rs2E        = rs2_q;

endmodule

// File: tb/tb_decode_cycle.sv
// Scoreboarded bench for decode_cycle: expectations queued at drive time,
// popped and compared one cycle later.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        FlushE, RegWriteW;
    logic [4:0]  RdW;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  RdE, Rs1E, Rs2E;

    always #5 clk = ~clk;

    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .ALUSrcE(ALUSrcE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E)
    );

    typedef struct {
        logic [9:0]  ctrl;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rd, rs1, rs2;
        logic        dchk;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m[32];
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else             n_pass++;
    endtask

    function automatic logic [9:0] ctl(input logic rw, input logic [1:0] rs, input logic mw,
                                       input logic j, input logic b, input logic [2:0] alu,
                                       input logic as);
        return {rw, rs, mw, j, b, alu, as};
    endfunction

    function automatic logic [9:0] ctrl_out();
        return {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE};
    endfunction

    function automatic logic [31:0] rdm(input logic [4:0] a, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0)          return 32'd0;
        if (we && wa == a)      return wd;
        return m[a];
    endfunction

    task automatic all_zero(input string tag);
        chk({tag, "_ctrl"}, {22'd0, ctrl_out()}, 32'd0);
        chk({tag, "_rd1"}, RD1E, 32'd0);
        chk({tag, "_rd2"}, RD2E, 32'd0);
        chk({tag, "_imm"}, ImmExtE, 32'd0);
        chk({tag, "_pc"}, PCE, 32'd0);
        chk({tag, "_pc4"}, PCPlus4E, 32'd0);
        chk({tag, "_idx"}, {17'd0, RdE, Rs1E, Rs2E}, 32'd0);
    endtask

    task automatic step(input string tag, input logic [31:0] instr, input logic flush,
                        input logic we, input logic [4:0] rdw, input logic [31:0] resw,
                        input logic [9:0] ctrl, input logic [31:0] imm, input logic dchk);
        exp_t        e, g;
        logic [31:0] pc;
        pc = $urandom & 32'hFFFF_FFFC;
        InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4; FlushE = flush;
        RegWriteW = we; RdW = rdw; ResultW = resw;
        e.ctrl = ctrl; e.imm = imm; e.pc = pc; e.pc4 = pc + 32'd4; e.dchk = dchk;
        e.rd = instr[11:7]; e.rs1 = instr[19:15]; e.rs2 = instr[24:20];
        e.rd1 = rdm(e.rs1, we, rdw, resw);
        e.rd2 = rdm(e.rs2, we, rdw, resw);
        sb.push_back(e);
        if (we && rdw != 5'd0) m[rdw] = resw;
        @(posedge clk); #1;
        g = sb.pop_front();
        if (g.dchk) begin
            chk({tag, "_ctrl"}, {22'd0, ctrl_out()}, {22'd0, g.ctrl});
            chk({tag, "_imm"}, ImmExtE, g.imm);
            chk({tag, "_rd1"}, RD1E, g.rd1);
            chk({tag, "_rd2"}, RD2E, g.rd2);
            chk({tag, "_pc"}, PCE, g.pc);
            chk({tag, "_pc4"}, PCPlus4E, g.pc4);
            chk({tag, "_idx"}, {17'd0, RdE, Rs1E, Rs2E}, {17'd0, g.rd, g.rs1, g.rs2});
        end else begin
            chk({tag, "_ctrl"}, {23'd0, ctrl_out() >> 1}, {23'd0, g.ctrl >> 1});
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m[i] = 32'd0;
        rst = 1'b0;
        FlushE = 1'b0;
        // Inputs toggle (including writeback) while held in reset.
        for (int i = 0; i < 3; i++) begin
            InstrD = $urandom; PCD = $urandom; PCPlus4D = $urandom; FlushE = $urandom;
            RegWriteW = 1'b1; RdW = 5'(i + 1); ResultW = $urandom;
            @(posedge clk); #1;
            all_zero("rst_hold");
        end
        rst = 1'b1;
        step("bubble", 32'h0000_0000, 0, 0, 5'd0, 32'd0, 10'd0, 32'd0, 1);
        step("rd_after_rst", 32'h0020_81B3, 0, 0, 5'd0, 32'd0, ctl(1,2'b00,0,0,0,3'b000,0), 32'd2, 1);
        step("addi", 32'h0050_0093, 0, 0, 5'd0, 32'd0, ctl(1,2'b00,0,0,0,3'b000,1), 32'd5, 1);
        step("wb_x1", 32'h0000_0000, 0, 1, 5'd1, 32'h100, 10'd0, 32'd0, 1);
        step("wb_x2", 32'h0000_0000, 0, 1, 5'd2, 32'hAB, 10'd0, 32'd0, 1);
        step("sw", 32'h0020_A423, 0, 0, 5'd0, 32'd0, ctl(0,2'b00,1,0,0,3'b000,1), 32'd8, 1);
        step("beq", 32'hFE20_8EE3, 0, 0, 5'd0, 32'd0, ctl(0,2'b00,0,0,1,3'b001,0), 32'hFFFF_FFFC, 1);
        step("bypass", 32'h0010_81B3, 0, 1, 5'd1, 32'h1234, ctl(1,2'b00,0,0,0,3'b000,0), 32'd1, 1);
        step("x0_wr", 32'h0000_01B3, 0, 1, 5'd0, 32'hDEAD, ctl(1,2'b00,0,0,0,3'b000,0), 32'd0, 1);
        step("sub", 32'h4020_8233, 0, 0, 5'd0, 32'd0, ctl(1,2'b00,0,0,0,3'b001,0), 32'h402, 1);
        step("slt", 32'h0020_A2B3, 0, 0, 5'd0, 32'd0, ctl(1,2'b00,0,0,0,3'b101,0), 32'd2, 1);
        step("or", 32'h0020_E333, 0, 0, 5'd0, 32'd0, ctl(1,2'b00,0,0,0,3'b011,0), 32'd2, 1);
        step("andi", 32'hFFF0_F393, 0, 0, 5'd0, 32'd0, ctl(1,2'b00,0,0,0,3'b010,1), 32'hFFFF_FFFF, 1);
        step("addi_f7", 32'h4000_8413, 0, 0, 5'd0, 32'd0, ctl(1,2'b00,0,0,0,3'b000,1), 32'h400, 1);
        step("lw", 32'hFF81_2483, 0, 0, 5'd0, 32'd0, ctl(1,2'b01,0,0,0,3'b000,1), 32'hFFFF_FFF8, 1);
        step("jal_pos", 32'h0080_00EF, 0, 0, 5'd0, 32'd0, ctl(1,2'b10,0,1,0,3'b000,0), 32'd8, 1);
        step("jal_neg", 32'hFFDF_F06F, 0, 0, 5'd0, 32'd0, ctl(1,2'b10,0,1,0,3'b000,0), 32'hFFFF_FFFC, 1);
        step("unknown", 32'h0000_007F, 0, 0, 5'd0, 32'd0, 10'd0, 32'd0, 1);
        step("flush_lw", 32'hFF81_2483, 1, 1, 5'd10, 32'hCAFE, 10'd0, 32'd0, 0);
        step("flush_wb", 32'h00A5_05B3, 0, 0, 5'd0, 32'd0, ctl(1,2'b00,0,0,0,3'b000,0), 32'd10, 1);
        step("pre_arst", 32'h0010_8093, 0, 0, 5'd0, 32'd0, ctl(1,2'b00,0,0,0,3'b000,1), 32'd1, 1);
        // Asynchronous reset mid-cycle, no clock edge before the check.
        FlushE = 1'b1;
        rst = 1'b0;
        #1;
        all_zero("arst");
        @(posedge clk); #1;
        all_zero("arst_hold");
        rst = 1'b1;
        for (int i = 0; i < 32; i++) m[i] = 32'd0;
        step("rf_cleared", 32'h00A5_05B3, 0, 0, 5'd0, 32'd0, ctl(1,2'b00,0,0,0,3'b000,0), 32'd10, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- Second pipeline stage of the 5-stage RV32I core; consumes the IF/ID outputs InstrD, PCD, PCPlus4D.
- Decodes the instruction, reads the register file and extends the immediate.
- Registers all results into the ID/EX pipeline register, one-cycle latency, toward the execute stage.
- Accepts the writeback port and an execute-stage flush, so a taken branch or jump (PCSrcE) bubbles the wrong-path instruction.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, register-file depth; x0 hardwired to zero.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- InstrD  input  32  instruction from IF/ID.
- PCD  input  32  PC of InstrD.
- PCPlus4D  input  32  PCD+4.
- FlushE  input  1  squash ID/EX contents (driven by PCSrcE).
- RegWriteW  input  1  writeback enable.
- RdW  input  5  writeback destination.
- ResultW  input  32  writeback data.
- RegWriteE  output  1  write destination in WB.
- ResultSrcE  output  2  00 ALU, 01 memory, 10 PC+4.
- MemWriteE  output  1  store.
- JumpE  output  1  jal.
- BranchE  output  1  beq.
- ALUControlE  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- ALUSrcE  output  1  0 = RD2, 1 = immediate.
- RD1E  output  32  rs1 data.
- RD2E  output  32  rs2 data.
- ImmExtE  output  32  sign-extended immediate.
- PCE  output  32  registered PCD.
- PCPlus4E  output  32  registered PCPlus4D.
- RdE  output  5  destination register.
- Rs1E  output  5  source 1 index.
- Rs2E  output  5  source 2 index.

Behaviour:
- rst low, asynchronous:
  - every output goes to 0;
  - all register-file entries go to 0;
  - outputs remain 0 while rst is low.
- Latency: InstrD present before edge N → decoded fields valid on outputs after edge N.
- Supported opcodes and control values:
  - lw 0000011: RegWrite=1, ALUSrc=1, ResultSrc=01, imm I-type, add.
  - sw 0100011: MemWrite=1, ALUSrc=1, imm S-type, add.
  - R-type 0110011: RegWrite=1, ALU op from funct3/funct7.
  - I-ALU 0010011: RegWrite=1, ALUSrc=1, imm I-type.
  - beq 1100011: Branch=1, imm B-type, sub.
  - jal 1101111: RegWrite=1, Jump=1, ResultSrc=10, imm J-type.
- ALU decode:
  - funct3 000: sub only when R-type and funct7[5]=1, otherwise add.
  - funct3 010: slt.
  - funct3 110: or.
  - funct3 111: and.
  - Other funct3 values: add.
- Unknown opcode, including InstrD=0 (fetch reset/bubble): all control outputs 0; data fields still registered. No exception is raised.
- Immediates:
  - I: sign-extend instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All sign-extended to 32 bits.
- Register file:
  - Two combinational read ports.
  - One write port, written on posedge clk when RegWriteW=1 and RdW≠0.
  - Reading x0 always returns 0.
- Write/read same cycle: when RegWriteW=1, RdW≠0 and RdW equals rs1 (or rs2), RD1E (RD2E) captures ResultW (write-first bypass).
- FlushE=1 at an edge:
  - RegWriteE, MemWriteE, JumpE, BranchE, ResultSrcE and ALUControlE load 0.
  - Data fields may load; they are don't-care.
  - The writeback write in the same cycle still occurs.
- FlushE together with reset: reset dominates.
- No stall input; decode advances every cycle.

Decomposition:
- Shared package decode_pkg:
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_IALU, OP_BRANCH, OP_JAL);
  - ALU control enum;
  - ResultSrc enum;
  - immediate-type enum;
  - XLEN.
- One natural sub-module: register_file (2R/1W, x0 hardwired, write-first bypass, async active-low clear).
- Main decoder, ALU decoder and sign extender stay inline in combinational blocks.

Test Plan:
- Reset: hold rst=0 with random inputs → every output 0; after release, InstrD=0 → all control outputs 0.
- addi: InstrD=0x00500093 (addi x1,x0,5) → next cycle RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=5, RdE=1, RD1E=0.
- Store: preload x1=0x100 and x2=0xAB via writeback, then InstrD=0x0020A423 (sw x2,8(x1)) → MemWriteE=1, RegWriteE=0, ImmExtE=8, RD1E=0x100, RD2E=0xAB.
- Branch: InstrD=0xFE208EE3 (beq x1,x2,-4) → BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC.
- Bypass: RegWriteW=1, RdW=1, ResultW=0x1234 in the same cycle as add x3,x1,x1 → RD1E=RD2E=0x1234. Repeat with RdW=0 → x0 still reads 0.
- Flush: FlushE=1 with a lw in InstrD → next cycle RegWriteE=MemWriteE=BranchE=JumpE=0 and ResultSrcE=0; a writeback in the same cycle is still committed.
